writeback: RTL and testbench

Write-back stage between the execution units and the register file's single write port. Merges single-cycle ALU results with long-latency LSU/MDU results, with ALU priority and a one-entry skid buffer for the LSU. Registers the winning write towards the register file. Maintains a 32-bit pending scoreboard for long-latency destinations and gives decode operand forwarding plus a hazard stall.

---
 rtl/writeback.sv | 128 ++++++++++++
 tb/tb_writeback.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Write-back stage: merges ALU and long-latency results onto the single register
// file write port, tracks pending long-latency destinations, and drives decode forwarding/stall.
module writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_waddr,
    input  logic [31:0] alu_wdata,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_waddr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ready,
    input  logic        dec_wren,
    input  logic [4:0]  dec_waddr,
    input  logic        iss_valid,
    input  logic        rden1,
    input  logic [4:0]  raddr1,
    input  logic        rden2,
    input  logic [4:0]  raddr2,
    output logic        fwd1,
    output logic [31:0] fdata1,
    output logic        fwd2,
    output logic [31:0] fdata2,
    output logic        stall,
    output logic        wren,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    logic        buf_valid;
    logic [4:0]  buf_waddr;
    logic [31:0] buf_wdata;
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    logic alu_ok, lsu_acc, lsu_ok;
    logic take_buf, take_lsu, to_buf;
    logic clr_en, set_en;
    logic [4:0] clr_addr;
    logic buf_hit1, out_hit1, buf_hit2, out_hit2;
    logic src1_ok, src2_ok, hazard1, hazard2, waw;

    assign lsu_ready = ~buf_valid;

    // x0 destinations are treated as if no result arrived; an x0 LSU result is still accepted.
    assign alu_ok   = alu_valid & (alu_waddr != 5'd0);
    assign lsu_acc  = lsu_valid & lsu_ready;
    assign lsu_ok   = lsu_acc & (lsu_waddr != 5'd0);

    assign take_buf = ~alu_ok & buf_valid;
    assign take_lsu = ~alu_ok & ~buf_valid & lsu_ok;
    assign to_buf   = alu_ok & lsu_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wren  <= 1'b0;
            waddr <= 5'd0;
            wdata <= 32'd0;
        end else if (alu_ok) begin
            wren  <= 1'b1;
            waddr <= alu_waddr;
            wdata <= alu_wdata;
        end else if (take_buf) begin
            wren  <= 1'b1;
            waddr <= buf_waddr;
            wdata <= buf_wdata;
        end else if (take_lsu) begin
            wren  <= 1'b1;
            waddr <= lsu_waddr;
            wdata <= lsu_wdata;
        end else begin
            wren  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_waddr <= 5'd0;
            buf_wdata <= 32'd0;
        end else if (to_buf) begin
            buf_valid <= 1'b1;
            buf_waddr <= lsu_waddr;
            buf_wdata <= lsu_wdata;
        end else if (take_buf) begin
            buf_valid <= 1'b0;
        end
    end

    // A long-latency destination stays pending until its result reaches the output stage.
    assign clr_en   = take_buf | take_lsu;
    assign clr_addr = take_buf ? buf_waddr : lsu_waddr;
    assign set_en   = iss_valid & ~stall & dec_wren & (dec_waddr != 5'd0);

    always_comb begin
        pending_nxt = pending;
        if (clr_en)
            pending_nxt[clr_addr] = 1'b0;
        if (set_en)
            pending_nxt[dec_waddr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= 32'd0;
        else
            pending <= pending_nxt;
    end

    assign src1_ok  = rden1 & (raddr1 != 5'd0);
    assign src2_ok  = rden2 & (raddr2 != 5'd0);
    assign buf_hit1 = src1_ok & buf_valid & (buf_waddr == raddr1);
    assign buf_hit2 = src2_ok & buf_valid & (buf_waddr == raddr2);
    assign out_hit1 = src1_ok & wren & (waddr == raddr1);
    assign out_hit2 = src2_ok & wren & (waddr == raddr2);

    // Buffer holds the younger value, so it wins over the output stage.
    assign fwd1   = buf_hit1 | out_hit1;
    assign fwd2   = buf_hit2 | out_hit2;
    assign fdata1 = buf_hit1 ? buf_wdata : (out_hit1 ? wdata : 32'd0);
    assign fdata2 = buf_hit2 ? buf_wdata : (out_hit2 ? wdata : 32'd0);

    assign hazard1 = src1_ok & pending[raddr1] & ~buf_hit1;
    assign hazard2 = src2_ok & pending[raddr2] & ~buf_hit2;
    assign waw     = dec_wren & (dec_waddr != 5'd0) & pending[dec_waddr];
    assign stall   = hazard1 | hazard2 | waw;

endmodule

// File: tb/tb_writeback.sv
// Directed-vector bench for writeback: a per-cycle vector table followed by
// a hand-written asynchronous-reset sequence with a full skid buffer.
module tb_writeback;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic        dec_wren;
    logic [4:0]  dec_waddr;
    logic        iss_valid;
    logic        rden1;
    logic [4:0]  raddr1;
    logic        rden2;
    logic [4:0]  raddr2;
    logic        fwd1;
    logic [31:0] fdata1;
    logic        fwd2;
    logic [31:0] fdata2;
    logic        stall;
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int n_chk  = 0;
    int n_fail = 0;

    writeback dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .lsu_valid (lsu_valid),
        .lsu_waddr (lsu_waddr),
        .lsu_wdata (lsu_wdata),
        .lsu_ready (lsu_ready),
        .dec_wren  (dec_wren),
        .dec_waddr (dec_waddr),
        .iss_valid (iss_valid),
        .rden1     (rden1),
        .raddr1    (raddr1),
        .rden2     (rden2),
        .raddr2    (raddr2),
        .fwd1      (fwd1),
        .fdata1    (fdata1),
        .fwd2      (fwd2),
        .fdata2    (fdata2),
        .stall     (stall),
        .wren      (wren),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_a;
        logic [31:0] alu_d;
        logic        lsu_v;
        logic [4:0]  lsu_a;
        logic [31:0] lsu_d;
        logic        dwren;
        logic [4:0]  dwaddr;
        logic        iss;
        logic        rd1;
        logic [4:0]  ra1;
        logic        rd2;
        logic [4:0]  ra2;
        logic        e_ready;
        logic        e_fwd1;
        logic [31:0] e_fd1;
        logic        e_fwd2;
        logic [31:0] e_fd2;
        logic        e_stall;
        logic        e_wren;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_waddr = 5'd0; alu_wdata = 32'd0;
        lsu_valid = 1'b0; lsu_waddr = 5'd0; lsu_wdata = 32'd0;
        dec_wren  = 1'b0; dec_waddr = 5'd0; iss_valid = 1'b0;
        rden1 = 1'b0; raddr1 = 5'd0; rden2 = 1'b0; raddr2 = 5'd0;
    endtask

    initial begin
        // Each row: inputs driven for one cycle; expected combinational outputs for those
        // inputs, and registered outputs produced by the previous row.
        //           alu_v  alu_a  alu_d         lsu_v  lsu_a  lsu_d         dwren  dwaddr iss    rd1    ra1    rd2    ra2    rdy    fwd1   fd1           fwd2   fd2           stall  wren   waddr  wdata
        vecs[0]  = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 1'b1, 32'h1234,     1'b0, 32'h0,        1'b0, 1'b1, 5'd5,  32'h1234};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 5'd7,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 5'd5,  32'h1234};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hBEEF,     1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 5'd7,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 5'd5,  32'h1234};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 5'd7,  1'b1, 1'b0, 32'h0,        1'b1, 32'hBEEF,     1'b0, 1'b1, 5'd7,  32'hBEEF};
        vecs[5]  = '{1'b1, 5'd4,  32'h55,       1'b1, 5'd3,  32'hAA,       1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 5'd7,  32'hBEEF};
        vecs[6]  = '{1'b1, 5'd6,  32'h66,       1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b1, 5'd3,  1'b1, 5'd4,  1'b0, 1'b1, 32'hAA,       1'b1, 32'h55,       1'b0, 1'b1, 5'd4,  32'h55};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b1, 5'd3,  1'b0, 5'd0,  1'b0, 1'b1, 32'hAA,       1'b0, 32'h0,        1'b0, 1'b1, 5'd6,  32'h66};
        vecs[8]  = '{1'b1, 5'd0,  32'hFF,       1'b1, 5'd0,  32'hEE,       1'b0, 5'd0,  1'b0, 1'b1, 5'd3,  1'b1, 5'd0,  1'b1, 1'b1, 32'hAA,       1'b0, 32'h0,        1'b0, 1'b1, 5'd3,  32'hAA};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 5'd3,  32'hAA};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99,       1'b1, 5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 5'd3,  32'hAA};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h77,       1'b1, 5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 5'd0,  1'b1, 1'b1, 32'h99,       1'b0, 32'h0,        1'b0, 1'b1, 5'd9,  32'h99};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b1, 5'd9,  1'b0, 5'd0,  1'b1, 1'b1, 32'h77,       1'b0, 32'h0,        1'b1, 1'b1, 5'd9,  32'h77};

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_wren",      {31'd0, wren},      32'd0);
        chk("reset_waddr",     {27'd0, waddr},     32'd0);
        chk("reset_wdata",     wdata,              32'd0);
        chk("reset_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("reset_stall",     {31'd0, stall},     32'd0);
        chk("reset_fwd",       {30'd0, fwd1, fwd2}, 32'd0);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            alu_valid = vecs[i].alu_v; alu_waddr = vecs[i].alu_a; alu_wdata = vecs[i].alu_d;
            lsu_valid = vecs[i].lsu_v; lsu_waddr = vecs[i].lsu_a; lsu_wdata = vecs[i].lsu_d;
            dec_wren  = vecs[i].dwren; dec_waddr = vecs[i].dwaddr; iss_valid = vecs[i].iss;
            rden1 = vecs[i].rd1; raddr1 = vecs[i].ra1; rden2 = vecs[i].rd2; raddr2 = vecs[i].ra2;
            #1;
            chk($sformatf("v%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vecs[i].e_ready});
            chk($sformatf("v%0d_fwd1", i),      {31'd0, fwd1},      {31'd0, vecs[i].e_fwd1});
            chk($sformatf("v%0d_fdata1", i),    fdata1,             vecs[i].e_fd1);
            chk($sformatf("v%0d_fwd2", i),      {31'd0, fwd2},      {31'd0, vecs[i].e_fwd2});
            chk($sformatf("v%0d_fdata2", i),    fdata2,             vecs[i].e_fd2);
            chk($sformatf("v%0d_stall", i),     {31'd0, stall},     {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_wren", i),      {31'd0, wren},      {31'd0, vecs[i].e_wren});
            chk($sformatf("v%0d_waddr", i),     {27'd0, waddr},     {27'd0, vecs[i].e_waddr});
            chk($sformatf("v%0d_wdata", i),     wdata,              vecs[i].e_wdata);
        end

        // Fill the buffer with a pending x10 result, then reset mid-cycle.
        @(negedge clk);
        idle_inputs();
        dec_wren = 1'b1; dec_waddr = 5'd10; iss_valid = 1'b1;
        #1;
        chk("issue_x10_stall", {31'd0, stall}, 32'd0);

        @(negedge clk);
        idle_inputs();
        lsu_valid = 1'b1; lsu_waddr = 5'd10; lsu_wdata = 32'hA0;
        alu_valid = 1'b1; alu_waddr = 5'd11; alu_wdata = 32'hB1;
        #1;
        chk("coll_lsu_ready", {31'd0, lsu_ready}, 32'd1);

        @(negedge clk);
        idle_inputs();
        rden1 = 1'b1; raddr1 = 5'd10; rden2 = 1'b1; raddr2 = 5'd9;
        #1;
        chk("buf_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("buf_fwd1",      {31'd0, fwd1},      32'd1);
        chk("buf_fdata1",    fdata1,             32'hA0);
        chk("buf_stall",     {31'd0, stall},     32'd1);
        chk("buf_wren",      {31'd0, wren},      32'd1);
        chk("buf_waddr",     {27'd0, waddr},     32'd11);
        chk("buf_wdata",     wdata,              32'hB1);

        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_wren",      {31'd0, wren},      32'd0);
        chk("mid_rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("mid_rst_stall",     {31'd0, stall},     32'd0);
        chk("mid_rst_fwd1",      {31'd0, fwd1},      32'd0);
        chk("mid_rst_fdata1",    fdata1,             32'd0);

        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst%0d_wren", i),      {31'd0, wren},      32'd0);
            chk($sformatf("post_rst%0d_lsu_ready", i), {31'd0, lsu_ready}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
